// File: rtl/norm_shift32_pkg.sv
// ============================================================================
// norm_shift32_pkg : shared constants and state encoding for the normalizer
// Rev 1.0
// ============================================================================
`default_nettype none

package norm_shift32_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Amount select for step 0; later steps shift this right by the step index.
  localparam logic [CNT_W-1:0] K_FIRST = 5'b10000;

endpackage

`default_nettype wire

// File: rtl/norm_step32.sv
// ============================================================================
// norm_step32 : one combinational normalization step (conditional shift by k)
// Rev 1.0
// ============================================================================
`default_nettype none

module norm_step32
  import norm_shift32_pkg::*;
(
  input  logic [WIDTH-1:0] i_w,
  input  logic [CNT_W-1:0] i_k,
  input  logic [CNT_W-1:0] i_c,
  output logic [WIDTH-1:0] o_w,
  output logic [CNT_W-1:0] o_c,
  output logic             o_shifted
);

  logic [WIDTH-1:0] w_mask;

  // Mask covers the top k bits; the one-hot select doubles as the amount.
  assign w_mask    = ~({WIDTH{1'b1}} >> i_k);
  assign o_shifted = (i_k != '0) && ((i_w & w_mask) == '0);
  assign o_w       = o_shifted ? (i_w << i_k) : i_w;
  assign o_c       = o_shifted ? (i_c + i_k) : i_c;

endmodule

`default_nettype wire

// File: rtl/norm_shift32.sv
// ============================================================================
// norm_shift32 : iterative 32-bit left normalizer with start/done handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module norm_shift32
  import norm_shift32_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Y,
  output logic [CNT_W-1:0] CNT,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [2:0]       r_step;
  logic [WIDTH-1:0] r_w;
  logic [CNT_W-1:0] r_c;
  logic             r_zin;
  logic [WIDTH-1:0] r_y;
  logic [CNT_W-1:0] r_cnt;
  logic             r_zero;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_k;
  logic [WIDTH-1:0] w_w_step;
  logic [CNT_W-1:0] w_c_step;
  logic             w_shifted;
  logic [WIDTH-1:0] w_w_nxt;
  logic [CNT_W-1:0] w_c_nxt;

  assign w_k = K_FIRST >> r_step;

  norm_step32 u_step (
    .i_w       (r_w),
    .i_k       (w_k),
    .i_c       (r_c),
    .o_w       (w_w_step),
    .o_c       (w_c_step),
    .o_shifted (w_shifted)
  );

  assign w_w_nxt = w_shifted ? w_w_step : r_w;
  assign w_c_nxt = w_shifted ? w_c_step : r_c;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE, ST_FIN: begin
        if (START) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_step == 3'd4) begin
          w_last      = 1'b1;
          w_state_nxt = ST_FIN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ZERO is staged in r_zin so the visible flag only changes with DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_step <= '0;
      r_w    <= '0;
      r_c    <= '0;
      r_zin  <= 1'b0;
      r_y    <= '0;
      r_cnt  <= '0;
      r_zero <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_RUN);
      r_done <= (w_state_nxt == ST_FIN);
      if (w_accept) begin
        r_w    <= D;
        r_c    <= '0;
        r_zin  <= (D == '0);
        r_step <= '0;
      end else if (r_state == ST_RUN) begin
        r_w    <= w_w_nxt;
        r_c    <= w_c_nxt;
        r_step <= r_step + 3'd1;
        if (w_last) begin
          r_y    <= w_w_nxt;
          r_cnt  <= w_c_nxt;
          r_zero <= r_zin;
        end
      end
    end
  end

  assign Y    = r_y;
  assign CNT  = r_cnt;
  assign ZERO = r_zero;
  assign BUSY = r_busy;
  assign DONE = r_done;

endmodule

`default_nettype wire
